// File: rtl/cpunc_axi_req_arbiter.sv
// Round-robin arbiter that shares the CPUNC AXI master port between N_REQ
// simple request/done requesters. One single-beat word transaction is in
// flight at a time; byte/half accesses are lane-steered on both directions.
module cpunc_axi_req_arbiter #(
  parameter int N_REQ          = 2,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                            CPUNC_ACLK,
  input  logic                            CPUNC_ARESETn,
  input  logic [N_REQ-1:0]                REQ_VALID,
  input  logic [N_REQ-1:0]                REQ_WE,
  input  logic [2*N_REQ-1:0]              REQ_SIZE,
  input  logic [AXI_ADDR_WIDTH*N_REQ-1:0] REQ_ADDR,
  input  logic [32*N_REQ-1:0]             REQ_WDATA,
  output logic [N_REQ-1:0]                REQ_DONE,
  output logic [31:0]                     RSP_RDATA,
  output logic                            RSP_ERR,
  output logic [AXI_ADDR_WIDTH-1:0]       CPUNC_AWADDR,
  output logic                            CPUNC_AWVALID,
  input  logic                            CPUNC_AWREADY,
  output logic [31:0]                     CPUNC_WDATA,
  output logic [3:0]                      CPUNC_WSTRB,
  output logic                            CPUNC_WLAST,
  output logic                            CPUNC_WVALID,
  input  logic                            CPUNC_WREADY,
  input  logic                            CPUNC_BRESP,
  input  logic                            CPUNC_BVALID,
  output logic                            CPUNC_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]       CPUNC_ARADDR,
  output logic                            CPUNC_ARVALID,
  input  logic                            CPUNC_ARREADY,
  input  logic [31:0]                     CPUNC_RDATA,
  input  logic                            CPUNC_RRESP,
  input  logic                            CPUNC_RLAST,
  input  logic                            CPUNC_RVALID,
  output logic                            CPUNC_RREADY
);

  localparam int IW = $clog2(N_REQ);

  generate
    if (AXI_DATA_WIDTH != 32) begin : g_bad_width
      $error("cpunc_axi_req_arbiter: only AXI_DATA_WIDTH=32 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_ARB_ERR, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t                    state;
  logic [IW-1:0]             ptr, owner;
  logic [1:0]                size_q, off_q;
  logic [N_REQ-1:0]          done_q;

  logic [N_REQ-1:0]          elig;
  logic                      gany;
  logic [IW-1:0]             gidx;
  int                        j;
  logic                      g_we, g_bad;
  logic [1:0]                g_size;
  logic [AXI_ADDR_WIDTH-1:0] g_addr, g_waddr;
  logic [31:0]               g_wdata, g_wlane, rd_lane;
  logic [3:0]                g_strb;
  logic                      aw_fin, w_fin;

  // RLAST carries no information for single-beat reads.
  logic unused_rlast;
  assign unused_rlast = CPUNC_RLAST;

  // The owner of the previous cycle's done pulse sits out one arbitration,
  // since its VALID may drop a cycle late.
  assign elig = REQ_VALID & ~done_q;

  // Round-robin search upward from the pointer, with wrap.
  always_comb begin
    gany = 1'b0;
    gidx = '0;
    j    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gany && elig[j]) begin
        gany = 1'b1;
        gidx = IW'(j);
      end
    end
  end

  // Pick the winner's request fields, check alignment and build the write lanes.
  always_comb begin
    g_we    = REQ_WE[gidx];
    g_size  = REQ_SIZE[2*gidx +: 2];
    g_addr  = REQ_ADDR[AXI_ADDR_WIDTH*gidx +: AXI_ADDR_WIDTH];
    g_wdata = REQ_WDATA[32*gidx +: 32];
    g_waddr = {g_addr[AXI_ADDR_WIDTH-1:2], 2'b00};
    g_bad   = (g_size == 2'd3) ||
              (g_size == 2'd1 && g_addr[0]) ||
              (g_size == 2'd2 && g_addr[1:0] != 2'b00);
    case (g_size)
      2'd0:    begin g_wlane = {4{g_wdata[7:0]}};  g_strb = 4'b0001 << g_addr[1:0]; end
      2'd1:    begin g_wlane = {2{g_wdata[15:0]}}; g_strb = 4'b0011 << g_addr[1:0]; end
      default: begin g_wlane = g_wdata;            g_strb = 4'b1111;               end
    endcase
  end

  // Extract and zero-extend the addressed lane of the read beat.
  always_comb begin
    case (size_q)
      2'd0:    rd_lane = {24'b0, CPUNC_RDATA[8*off_q +: 8]};
      2'd1:    rd_lane = {16'b0, off_q[1] ? CPUNC_RDATA[31:16] : CPUNC_RDATA[15:0]};
      default: rd_lane = CPUNC_RDATA;
    endcase
  end

  // A write channel is finished once its VALID is gone or is being accepted now.
  always_comb begin
    aw_fin = !CPUNC_AWVALID || CPUNC_AWREADY;
    w_fin  = !CPUNC_WVALID  || CPUNC_WREADY;
  end

  // Transaction FSM; every output is a flop.
  always_ff @(posedge CPUNC_ACLK or negedge CPUNC_ARESETn) begin
    if (!CPUNC_ARESETn) begin
      state         <= S_IDLE;
      ptr           <= '0;
      owner         <= '0;
      size_q        <= '0;
      off_q         <= '0;
      done_q        <= '0;
      REQ_DONE      <= '0;
      RSP_RDATA     <= '0;
      RSP_ERR       <= 1'b0;
      CPUNC_AWADDR  <= '0;
      CPUNC_AWVALID <= 1'b0;
      CPUNC_WDATA   <= '0;
      CPUNC_WSTRB   <= '0;
      CPUNC_WLAST   <= 1'b0;
      CPUNC_WVALID  <= 1'b0;
      CPUNC_BREADY  <= 1'b0;
      CPUNC_ARADDR  <= '0;
      CPUNC_ARVALID <= 1'b0;
      CPUNC_RREADY  <= 1'b0;
    end else begin
      REQ_DONE <= '0;
      done_q   <= REQ_DONE;
      case (state)
        S_IDLE: if (gany) begin
          owner  <= gidx;
          size_q <= g_size;
          off_q  <= g_addr[1:0];
          ptr    <= (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;
          if (g_bad) begin
            state <= S_ARB_ERR;
          end else if (g_we) begin
            state         <= S_AW_W;
            CPUNC_AWADDR  <= g_waddr;
            CPUNC_AWVALID <= 1'b1;
            CPUNC_WDATA   <= g_wlane;
            CPUNC_WSTRB   <= g_strb;
            CPUNC_WVALID  <= 1'b1;
            CPUNC_WLAST   <= 1'b1;
          end else begin
            state         <= S_AR;
            CPUNC_ARADDR  <= g_waddr;
            CPUNC_ARVALID <= 1'b1;
          end
        end
        S_ARB_ERR: begin
          RSP_ERR         <= 1'b1;
          RSP_RDATA       <= '0;
          REQ_DONE[owner] <= 1'b1;
          state           <= S_DONE;
        end
        S_AR: if (CPUNC_ARREADY) begin
          CPUNC_ARVALID <= 1'b0;
          CPUNC_RREADY  <= 1'b1;
          state         <= S_R;
        end
        S_R: if (CPUNC_RVALID) begin
          CPUNC_RREADY    <= 1'b0;
          RSP_RDATA       <= rd_lane;
          RSP_ERR         <= CPUNC_RRESP;
          REQ_DONE[owner] <= 1'b1;
          state           <= S_DONE;
        end
        S_AW_W: begin
          if (CPUNC_AWREADY) CPUNC_AWVALID <= 1'b0;
          if (CPUNC_WREADY) begin
            CPUNC_WVALID <= 1'b0;
            CPUNC_WLAST  <= 1'b0;
          end
          if (aw_fin && w_fin) begin
            CPUNC_BREADY <= 1'b1;
            state        <= S_B;
          end
        end
        S_B: if (CPUNC_BVALID) begin
          CPUNC_BREADY    <= 1'b0;
          RSP_ERR         <= CPUNC_BRESP;
          REQ_DONE[owner] <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpunc_axi_req_arbiter.sv
// Bench for cpunc_axi_req_arbiter: a reactive AXI slave, a completion
// scoreboard fed by the stimulus tasks, and per-scenario inline checks.
module tb_cpunc_axi_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_we, req_done;
  logic [2*N-1:0]  req_size;
  logic [AW*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wlast, wvalid, wready, bresp, bvalid, bready;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic            arvalid, arready, rresp, rlast, rvalid, rready;

  cpunc_axi_req_arbiter #(.N_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32)) dut (
    .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
    .REQ_VALID(req_valid), .REQ_WE(req_we), .REQ_SIZE(req_size), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_DONE(req_done), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .CPUNC_AWADDR(awaddr), .CPUNC_AWVALID(awvalid), .CPUNC_AWREADY(awready),
    .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast), .CPUNC_WVALID(wvalid),
    .CPUNC_WREADY(wready), .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid), .CPUNC_BREADY(bready),
    .CPUNC_ARADDR(araddr), .CPUNC_ARVALID(arvalid), .CPUNC_ARREADY(arready),
    .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RLAST(rlast), .CPUNC_RVALID(rvalid),
    .CPUNC_RREADY(rready)
  );

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] mon_oh;
  int n_checks = 0;
  int n_fail   = 0;

  // slave knobs and state
  int          sl_aw_hold = 1, sl_w_hold = 1;
  logic        sl_rdrop = 1'b0, sl_rresp = 1'b0, sl_bresp = 1'b0;
  logic [31:0] sl_rdata = 32'h0;
  int          b_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;

  // Reactive slave: handshake effects are applied one negedge after the posedge they occur on.
  initial begin
    arready = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 1'b0; rlast = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
        aw_cnt = 0; w_cnt = 0;
      end else begin
        if (r_hs) rvalid = 1'b0;
        if (b_hs) bvalid = 1'b0;
        if (ar_hs && !sl_rdrop) begin rvalid = 1'b1; rdata = sl_rdata; rresp = sl_rresp; end
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got  = 1;
        if (aw_got && w_got) begin bvalid = 1'b1; bresp = sl_bresp; aw_got = 0; w_got = 0; end
        awready = awvalid && (aw_cnt + 1 >= sl_aw_hold);
        wready  = wvalid  && (w_cnt + 1 >= sl_w_hold);
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        if (aw_hs) aw_cnt = 0; else if (awvalid) aw_cnt++;
        if (w_hs)  w_cnt = 0;  else if (wvalid)  w_cnt++;
        if (b_hs) b_cnt++;
      end
    end
  end

  // Completion scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && req_done != '0) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: REQ_DONE=%b with no pending expectation", req_done);
      end else begin
        mon_e = sb.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.owner] = 1'b1;
        n_checks++;
        if (req_done !== mon_oh) begin
          n_fail++; $display("FAIL done_owner: REQ_DONE=%b expected %b", req_done, mon_oh);
        end
        n_checks++;
        if (rsp_err !== mon_e.err) begin
          n_fail++; $display("FAIL rsp_err: got %b expected %b", rsp_err, mon_e.err);
        end
        if (mon_e.chk_rdata) begin
          n_checks++;
          if (rsp_rdata !== mon_e.rdata) begin
            n_fail++; $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, mon_e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic we, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [31:0] wd);
    req_we[i] = we;
    req_size[2*i +: 2] = sz;
    req_addr[AW*i +: AW] = a;
    req_wdata[32*i +: 32] = wd;
  endtask

  // Wait for n done pulses, releasing each owner's VALID (or all at the end when hold=1).
  task automatic wait_dones(input int n, input int bound, input bit hold,
                            output int last_k, output bit ok);
    int cnt;
    cnt = 0; ok = 0; last_k = 0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (req_done != '0) begin
        cnt++;
        if (!hold) req_valid &= ~req_done;
        else if (cnt == n) req_valid = '0;
        if (cnt == n) begin last_k = k; ok = 1; break; end
      end
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({req_done, rsp_rdata, rsp_err, awaddr, awvalid, wdata, wstrb, wlast,
                 wvalid, bready, araddr, arvalid, rready});
  endfunction

  task automatic test_reset();
    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs()); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", outs()); end
  endtask

  task automatic test_read_byte();
    int dk; bit got;
    repeat (2) @(negedge clk);
    sl_rdata = 32'hAABBCCDD; sl_rresp = 1'b0;
    set_req(0, 1'b0, 2'd0, 12'h013, 32'h0);
    sb.push_back('{0, 32'h000000AA, 1'b0, 1'b1});
    req_valid[0] = 1'b1;
    got = 0; dk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 12'h010) begin
          n_fail++; $display("FAIL read_ar: ARVALID=%b ARADDR=%h expected 1/010", arvalid, araddr);
        end
      end
      if (req_done != '0) begin req_valid[0] = 1'b0; dk = k; got = 1; break; end
    end
    n_checks++;
    if (!got || dk != 3) begin n_fail++; $display("FAIL read_latency: done at cycle %0d expected 3", dk); end
  endtask

  task automatic test_write_half();
    int aw_cyc, w_cyc, b0; bit got;
    repeat (2) @(negedge clk);
    sl_aw_hold = 3; sl_w_hold = 1; sl_bresp = 1'b0; b0 = b_cnt;
    set_req(1, 1'b1, 2'd1, 12'h022, 32'h00001234);
    sb.push_back('{1, 32'h0, 1'b0, 1'b0});
    req_valid[1] = 1'b1;
    aw_cyc = 0; w_cyc = 0; got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (k == 1) begin
        n_checks++;
        if (awaddr !== 12'h020 || wdata !== 32'h12341234 || wstrb !== 4'b1100 || wlast !== 1'b1) begin
          n_fail++;
          $display("FAIL write_fields: AWADDR=%h WDATA=%h WSTRB=%b WLAST=%b expected 020/12341234/1100/1",
                   awaddr, wdata, wstrb, wlast);
        end
      end
      if (req_done != '0) begin req_valid[1] = 1'b0; got = 1; break; end
    end
    n_checks++;
    if (!got || aw_cyc != 3 || w_cyc != 1 || b_cnt - b0 != 1) begin
      n_fail++;
      $display("FAIL write_handshakes: done=%0d aw_cycles=%0d w_cycles=%0d b=%0d expected 1/3/1/1",
               got, aw_cyc, w_cyc, b_cnt - b0);
    end
    sl_aw_hold = 1;
  endtask

  task automatic test_back_to_back();
    int dk; bit ok;
    repeat (2) @(negedge clk);
    sl_rdata = 32'hAABBCCDD; sl_rresp = 1'b0;
    set_req(0, 1'b0, 2'd0, 12'h010, 32'h0);
    set_req(1, 1'b0, 2'd1, 12'h012, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{0, 32'h000000DD, 1'b0, 1'b1});
      sb.push_back('{1, 32'h0000AABB, 1'b0, 1'b1});
    end
    req_valid = 2'b11;
    wait_dones(4, 60, 1'b1, dk, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: fewer than 4 dones got 0 expected 4"); end
  endtask

  task automatic test_misaligned();
    logic [1:0]    szs [2];
    logic [AW-1:0] ads [2];
    int dk; bit got, saw_ar;
    szs[0] = 2'd2; ads[0] = 12'h006;
    szs[1] = 2'd3; ads[1] = 12'h008;
    for (int r = 0; r < 2; r++) begin
      repeat (2) @(negedge clk);
      set_req(r, 1'b0, szs[r], ads[r], 32'h0);
      sb.push_back('{r, 32'h0, 1'b1, 1'b1});
      req_valid[r] = 1'b1;
      got = 0; saw_ar = 0; dk = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (arvalid || awvalid) saw_ar = 1;
        if (req_done != '0) begin req_valid[r] = 1'b0; dk = k; got = 1; break; end
      end
      n_checks++;
      if (!got || dk != 2 || saw_ar) begin
        n_fail++; $display("FAIL misaligned_%0d: done cycle %0d bus=%0d expected 2/0", r, dk, saw_ar);
      end
    end
  endtask

  task automatic test_resp_err();
    int dk; bit ok;
    repeat (2) @(negedge clk);
    sl_bresp = 1'b1;
    set_req(0, 1'b1, 2'd2, 12'h040, 32'hDEADBEEF);
    sb.push_back('{0, 32'h0, 1'b1, 1'b0});
    req_valid[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wdata !== 32'hDEADBEEF || wstrb !== 4'b1111 || awaddr !== 12'h040) begin
      n_fail++; $display("FAIL word_write: WDATA=%h WSTRB=%b AWADDR=%h expected DEADBEEF/1111/040",
                         wdata, wstrb, awaddr);
    end
    wait_dones(1, 20, 1'b0, dk, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bresp_timeout: no done got 0 expected 1"); end
    sl_bresp = 1'b0;
    repeat (2) @(negedge clk);
    sl_rresp = 1'b1; sl_rdata = 32'h55667788;
    set_req(1, 1'b0, 2'd2, 12'h044, 32'h0);
    sb.push_back('{1, 32'h55667788, 1'b1, 1'b1});
    req_valid[1] = 1'b1;
    wait_dones(1, 20, 1'b0, dk, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rresp_timeout: no done got 0 expected 1"); end
    sl_rresp = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dk; bit ok, in_r;
    repeat (2) @(negedge clk);
    sl_rdrop = 1'b1;
    set_req(0, 1'b0, 2'd2, 12'h050, 32'h0);
    req_valid[0] = 1'b1;
    in_r = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rready) begin in_r = 1; break; end
    end
    n_checks++;
    if (!in_r) begin n_fail++; $display("FAIL reach_r: RREADY never seen got 0 expected 1"); end
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", outs()); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_done !== '0) begin n_fail++; $display("FAIL aborted_done: REQ_DONE=%b expected 0", req_done); end
    end
    rst_n = 1'b1;
    sl_rdrop = 1'b0;
    repeat (2) @(negedge clk);
    sl_rdata = 32'hAABBCCDD;
    set_req(0, 1'b0, 2'd0, 12'h011, 32'h0);
    set_req(1, 1'b0, 2'd1, 12'h020, 32'h0);
    sb.push_back('{0, 32'h000000CC, 1'b0, 1'b1});
    sb.push_back('{1, 32'h0000CCDD, 1'b0, 1'b1});
    req_valid = 2'b11;
    wait_dones(2, 40, 1'b0, dk, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL post_reset_timeout: dones missing got 0 expected 2"); end
  endtask

  initial begin
    test_reset();
    test_read_byte();
    test_write_half();
    test_back_to_back();
    test_misaligned();
    test_resp_err();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpunc_axi_req_arbiter.md
Name: cpunc_axi_req_arbiter

Overview:
- Shares the single CPUNC AXI master port between N_REQ simple request/done requesters, for example the Spike agent plus a debug/loader master.
- Round-robin arbitration. One transaction is outstanding at a time.
- Converts byte/half/word requests into single-beat word AXI transactions and performs lane steering for writes and reads.
- Sits between the requesters and the CPUNC slave; the fixed AXI side-band signals (IDs, LEN=0, SIZE=2'b10, BURST/LOCK/CACHE/PROT/QOS=0) are tied off outside this block.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- AXI_ADDR_WIDTH, 12, byte address width.
- AXI_DATA_WIDTH, 32, data width; only 32 is supported (elaboration error otherwise).

Ports:
- CPUNC_ACLK  in  1  clock
- CPUNC_ARESETn  in  1  asynchronous active-low reset
- REQ_VALID  in  N_REQ  request pending, per requester; held until REQ_DONE
- REQ_WE  in  N_REQ  1=write, 0=read
- REQ_SIZE  in  2*N_REQ  0=byte, 1=half, 2=word, 3=illegal
- REQ_ADDR  in  AXI_ADDR_WIDTH*N_REQ  byte address
- REQ_WDATA  in  32*N_REQ  write data, right-aligned
- REQ_DONE  out  N_REQ  one-cycle completion pulse to the owner
- RSP_RDATA  out  32  read data, zero-extended, valid with REQ_DONE
- RSP_ERR  out  1  error flag, valid with REQ_DONE
- CPUNC_AWADDR  out  AXI_ADDR_WIDTH  word-aligned write address
- CPUNC_AWVALID  out  1
- CPUNC_AWREADY  in  1
- CPUNC_WDATA  out  32
- CPUNC_WSTRB  out  4
- CPUNC_WLAST  out  1  always 1 when WVALID
- CPUNC_WVALID  out  1
- CPUNC_WREADY  in  1
- CPUNC_BRESP  in  1
- CPUNC_BVALID  in  1
- CPUNC_BREADY  out  1
- CPUNC_ARADDR  out  AXI_ADDR_WIDTH  word-aligned read address
- CPUNC_ARVALID  out  1
- CPUNC_ARREADY  in  1
- CPUNC_RDATA  in  32
- CPUNC_RRESP  in  1
- CPUNC_RLAST  in  1  ignored
- CPUNC_RVALID  in  1
- CPUNC_RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs, REQ_DONE, RSP_ERR = 0; RSP_RDATA, addresses, WDATA, WSTRB = 0; round-robin pointer = 0; state IDLE.
- Reset asserted mid-transaction: immediate return to IDLE; no REQ_DONE is issued for the aborted request.
- All outputs are registered.
- States: IDLE, ARB_ERR, AR, R, AW_W, B, DONE.
- IDLE, arbitration: with any REQ_VALID set, grant the first set bit searching upward (with wrap) from the pointer. Latch the owner index, WE, SIZE, ADDR[1:0] and WDATA. Set pointer = owner+1 mod N_REQ.
- IDLE, next state:
  - Illegal size (3), half with ADDR[0]=1, or word with ADDR[1:0]!=0 -> ARB_ERR (no bus access).
  - Otherwise, read -> AR; write -> AW_W.
- A requester whose REQ_DONE pulsed this cycle is not eligible in the same cycle (its VALID may lag).
- AR: ARVALID=1 and ARADDR={ADDR[AW-1:2],2'b00}, both set on entry. Held stable until ARREADY is sampled high, then clear ARVALID and go to R.
- R: RREADY=1. On RVALID, capture the data:
  - byte: RDATA[8*off+:8]
  - half: RDATA[16*off[1]+:16]
  - word: all 32 bits
  - Zero-extend to 32 bits. RSP_ERR=RRESP. Go to DONE.
- AW_W: AWVALID and WVALID are both asserted on entry. WDATA = the data lane replicated (byte ×4, half ×2, word as-is). WSTRB:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- AW_W handshakes: each VALID drops independently on its own READY. A simultaneous AWREADY and WREADY completes both in one cycle. Go to B once both handshakes have completed.
- B: BREADY=1. On BVALID, RSP_ERR=BRESP, go to DONE.
- ARB_ERR: RSP_ERR=1, RSP_RDATA=0, go to DONE.
- DONE: REQ_DONE[owner]=1 for exactly one cycle with RSP_RDATA/RSP_ERR. Next cycle: IDLE. RSP_RDATA holds until the next DONE.
- Latency, zero-wait slave: read REQ_VALID -> REQ_DONE = 4 cycles (IDLE, AR, R, DONE); write = 4 cycles (IDLE, AW_W, B, DONE).
- Request inputs are sampled only in IDLE. Changes to REQ_* after grant are ignored until DONE.
- A requester dropping REQ_VALID before DONE does not abort the transaction.

Test Plan:
- Single read, size 1, ADDR=0x013, RDATA=0xAABBCCDD, zero-wait slave -> ARADDR=0x010, REQ_DONE[0] in the 4th cycle, RSP_RDATA=0x000000AA, RSP_ERR=0.
- Write, size 2, ADDR=0x022, WDATA=0x1234 -> AWADDR=0x020, WDATA=0x12341234, WSTRB=4'b1100. AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID after 3, exactly one B handshake.
- Both requesters hold REQ_VALID continuously with reads -> grants alternate 0,1,0,1. Each DONE pulse goes only to the granted index.
- Word read at ADDR=0x006 -> no ARVALID ever; REQ_DONE 3 cycles after request with RSP_ERR=1, RSP_RDATA=0. Same for REQ_SIZE=3.
- BRESP=1 on a word write -> RSP_ERR=1 at DONE. RRESP=1 on a read -> RSP_ERR=1 with the data still returned.
- CPUNC_ARESETn pulled low while in R with RVALID=0 -> all outputs return to reset values immediately, no REQ_DONE. After release, a new request completes normally with the pointer back at 0.
